// File: rtl/serial_tx_frame_if.sv
// Byte-stream handshake between the message printer / USB side and the UART
// transmit stage, plus the serial tx line itself.
interface serial_tx_frame_if;
  logic       block;
  logic       busy;
  logic [7:0] data;
  logic       new_data;
  logic       tx;

  // Upstream drives the byte stream and hold-off; the transmitter answers.
  modport master (
    output block,
    output data,
    output new_data,
    input  busy,
    input  tx
  );

  modport slave (
    input  block,
    input  data,
    input  new_data,
    output busy,
    output tx
  );
endinterface

// File: rtl/serial_tx_frame.sv
// UART 8N1 transmit stage: start bit, 8 data bits LSB first, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx_frame #(
  parameter int CLK_PER_BIT = 50,
  parameter int CTR_SIZE    = 6
) (
  input  logic             clk,
  input  logic             rst,
  serial_tx_frame_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA,
`ifdef SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP_BIT
  } state_t;

  localparam logic [CTR_SIZE-1:0] LAST_CTR = CTR_SIZE'(CLK_PER_BIT - 1);

  state_t              state_q, state_d;
  logic [CTR_SIZE-1:0] ctr_q, ctr_d;
  logic [2:0]          bitIdx_q, bitIdx_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                ctrWrap;
`ifdef SERIAL_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  // State and registered outputs; tx/busy are loaded with the value for the
  // state being entered so they never depend combinationally on inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ctr_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign ctrWrap = (ctr_q == LAST_CTR);

  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        ctr_d    = '0;
        bitIdx_d = '0;
        tx_d     = 1'b1;
        if (!bus.block && bus.new_data) begin
          state_d  = START_BIT;
          shift_d  = bus.data;
          tx_d     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^bus.data;
`endif
        end
      end

      START_BIT: begin
        if (ctrWrap) begin
          state_d = DATA;
          ctr_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          ctr_d = ctr_q + CTR_SIZE'(1);
        end
      end

      // The shift register always holds the next data bit in its LSB.
      DATA: begin
        if (ctrWrap) begin
          ctr_d = '0;
          if (bitIdx_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP_BIT;
            tx_d    = 1'b1;
`endif
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
            tx_d     = shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
          end
        end else begin
          ctr_d = ctr_q + CTR_SIZE'(1);
        end
      end

`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (ctrWrap) begin
          state_d = STOP_BIT;
          ctr_d   = '0;
          tx_d    = 1'b1;
        end else begin
          ctr_d = ctr_q + CTR_SIZE'(1);
        end
      end
`endif

      STOP_BIT: begin
        tx_d = 1'b1;
        if (ctrWrap) begin
          state_d = IDLE;
          ctr_d   = '0;
        end else begin
          ctr_d = ctr_q + CTR_SIZE'(1);
        end
      end

      default: begin
        state_d = IDLE;
        ctr_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    // In IDLE, block alone holds busy high; during a frame busy is always set.
    busy_d = (state_d != IDLE) || bus.block;
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;

endmodule

// File: doc/serial_tx_frame.md
Name: serial_tx_frame

Overview:
- UART transmit stage directly downstream of the message printer. It consumes the printer's tx_data/new_tx_data byte stream and returns tx_busy as flow control.
- Serialises each accepted byte into an 8N1 frame on the tx pin, LSB first: 1 start bit, 8 data bits, 1 stop bit.
- An optional even-parity bit sits between the data bits and the stop bit.
- A block input lets the USB/AVR side hold off transmission while it is not ready.

Parameters:
- CLK_PER_BIT, default 50: clk cycles per serial bit (50 MHz clk, 1 Mbaud). Legal range is 2 and up.
- CTR_SIZE, default 6: width of the bit-period counter. Must satisfy 2^CTR_SIZE >= CLK_PER_BIT.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- block  in  1  1 = downstream not ready; no new frame is started.
- busy  out  1  1 = new_data will be ignored; this is the tx_busy of the upstream printer.
- data  in  8  byte to send; sampled only on the accept cycle.
- new_data  in  1  single-cycle request to send data.
- tx  out  1  serial line; idle level is 1.

Behaviour:
- Reset values: tx=1, busy=0, state=IDLE, bit counter=0, bit index=0, shift register=0.
- tx and busy are registered outputs; neither depends combinationally on any input.
- States: IDLE, START_BIT, DATA, PARITY (only when the feature macro is defined), STOP_BIT.
- Accept rule: at a rising edge with state=IDLE, block=0, new_data=1:
  - data is latched and state goes to START_BIT.
  - In the next cycle busy=1 and tx=0.
  - Upstream may therefore drive new_data whenever it sees busy=0, and is guaranteed busy=1 on the following cycle.
- Cycle timing, where k is the accept edge:
  - START_BIT occupies cycles k+1 .. k+CLK_PER_BIT.
  - Data bit i (i=0..7) occupies CLK_PER_BIT cycles starting at k+1+(i+1)*CLK_PER_BIT.
  - STOP_BIT (tx=1) follows for CLK_PER_BIT cycles.
  - The frame is 10*CLK_PER_BIT cycles (11*CLK_PER_BIT with parity).
- The bit counter runs 0..CLK_PER_BIT-1, then wraps to 0 and advances the bit or state.
  - DATA exits to STOP_BIT (or PARITY) when the bit index reaches 7 and the counter wraps.
- End of frame: on the last cycle of STOP_BIT, the next cycle has state=IDLE, tx=1 and busy=0 (or busy=1 if block=1).
  - A new_data in that first IDLE cycle is accepted, giving back-to-back frames with no idle gap beyond the stop bit.
- block handling:
  - In IDLE, block=1 forces busy=1 (registered, one cycle after block rises) and new_data is ignored.
  - block is ignored once a frame has started; the frame always completes.
- new_data while busy=1 is dropped; no queuing. data changing mid-frame has no effect.
- Simultaneous block=1 and new_data=1 in IDLE: not accepted, and no frame is sent.
- rst mid-frame: on the next cycle tx=1, busy=0 and state=IDLE. The partial frame is truncated and no stop bit is sent.

Optional Feature:
- Macro SERIAL_TX_PARITY_EN.
- Defined:
  - A PARITY state of CLK_PER_BIT cycles is inserted between DATA and STOP_BIT.
  - tx = XOR of the 8 latched data bits (even parity).
  - Frame length becomes 11*CLK_PER_BIT.
- Undefined: no PARITY state, no parity logic, and the frame is exactly 10*CLK_PER_BIT.

Test Plan:
- Reset held 3 cycles, then released with no stimulus -> tx=1, busy=0 on every cycle.
- CLK_PER_BIT=4; data=8'h31 with a new_data pulse at edge k:
  - busy=1 from k+1 to k+40.
  - tx, in 4-cycle bits: 0, 1,0,0,0,1,1,0,0, 1.
  - busy=0 at k+41.
- Same stimulus with SERIAL_TX_PARITY_EN defined:
  - tx bits: 0, 1,0,0,0,1,1,0,0, 1(parity), 1(stop).
  - busy=0 at k+45.
- Back-to-back traffic: upstream drives new_data on the first cycle busy=0, sending 8'h30 then 8'h31.
  - The second start bit begins immediately after the first stop bit; no extra idle cycles.
  - Stray new_data pulses injected mid-frame are ignored.
- block=1 in IDLE with new_data pulses -> busy=1 the cycle after block rises and tx stays 1. On block=0, the next new_data with 8'h55 gives tx bits 0,1,0,1,0,1,0,1,0,1.
- block asserted mid-frame -> the frame completes unchanged. rst pulsed during data bit 3 -> tx=1 and busy=0 on the next cycle, and the following byte is accepted normally.
